// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dm_arbiter_wait_counter.sv
// Counts consecutive cycles a DMA request has been blocked by the core.
module wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             asyn_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dm_arbiter.sv
// Shares the data-memory port between the core (fixed priority) and a DMA
// requester; a bounded wait forces a one-cycle core stall for the DMA.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              asyn_rst,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_t       state, state_nxt;
  logic             gnt_raw, stall_raw;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt;

  wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .asyn_rst (asyn_rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_raw   = 1'b0;
    stall_raw = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (dma_req) begin
          if (!cpu_en) begin
            gnt_raw = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_inc   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!dma_req) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (!cpu_en) begin
          gnt_raw   = 1'b1;
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (cnt_tc) begin
          state_nxt = FORCE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FORCE: begin
        gnt_raw   = 1'b1;
        stall_raw = 1'b1;
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Reset masks the combinational grant/stall so the port falls back to the core at once.
  assign dma_gnt   = gnt_raw & ~asyn_rst;
  assign cpu_stall = stall_raw & ~asyn_rst;

  assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_d     = dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_gnt ? dma_we    : (cpu_we & cpu_en);
  assign cpu_rdata = mem_q;

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else if (dma_gnt && !dma_we) begin
      dma_rvalid <= 1'b1;
      dma_rdata  <= mem_q;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural data memory.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        asyn_rst;
  logic        cpu_en, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] mem [0:255];
  logic [31:0] sb [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk        (clk),
    .asyn_rst   (asyn_rst),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_q      (mem_q)
  );

  assign mem_q = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic c_en, input logic c_we, input logic [15:0] c_a,
                       input logic [31:0] c_d, input logic d_req, input logic d_we,
                       input logic [15:0] d_a, input logic [31:0] d_d);
    cpu_en = c_en; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    dma_req = d_req; dma_we = d_we; dma_addr = d_a; dma_wdata = d_d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read-return scoreboard: every DMA read grant pushes its expected data.
  always @(negedge clk) begin
    if (!asyn_rst && dma_rvalid) begin
      if (sb.size() == 0) check_eq("rvalid_unexpected", 32'(dma_rvalid), 32'd0);
      else check_eq("dma_rdata", dma_rdata, sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    asyn_rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0077, 32'h0, 1'b1, 1'b1, 16'h0010, 32'h1111_2222);
    @(negedge clk);
    check_eq("rst_gnt", 32'(dma_gnt), 32'd0);
    check_eq("rst_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check_eq("rst_rdata", dma_rdata, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0077);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    asyn_rst = 1'b0;

    // Free port DMA write, then preload two read locations
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("free_gnt", 32'(dma_gnt), 32'd1);
    check_eq("free_mem_we", 32'(mem_we), 32'd1);
    check_eq("free_mem_addr", 32'(mem_addr), 32'h0010);
    check_eq("free_mem_d", mem_d, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0020, 32'h1234_5678);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0040, 32'hCAFE_F00D);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check_eq("core_load", cpu_rdata, 32'hDEAD_BEEF);
    check_eq("core_load_gnt", 32'(dma_gnt), 32'd0);
    check_eq("core_load_we", 32'(mem_we), 32'd0);
    next_cycle();

    // Back-to-back free-port DMA reads
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
    sb.push_back(32'hCAFE_F00D);
    @(negedge clk);
    check_eq("b2b_gnt0", 32'(dma_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
    sb.push_back(32'h1234_5678);
    @(negedge clk);
    check_eq("b2b_gnt1", 32'(dma_gnt), 32'd1);
    check_eq("b2b_rvalid1", 32'(dma_rvalid), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check_eq("b2b_rvalid2", 32'(dma_rvalid), 32'd1);
    next_cycle();

    // Collision: core busy two cycles, then free
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
      @(negedge clk);
      check_eq("coll_gnt_blocked", 32'(dma_gnt), 32'd0);
      check_eq("coll_stall", 32'(cpu_stall), 32'd0);
      check_eq("coll_core_addr", 32'(mem_addr), 32'h0010);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
    sb.push_back(32'hCAFE_F00D);
    @(negedge clk);
    check_eq("coll_gnt_third", 32'(dma_gnt), 32'd1);
    check_eq("coll_stall3", 32'(cpu_stall), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    next_cycle();

    // Starvation: continuous core traffic, DMA read of 0x0020
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
      @(negedge clk);
      check_eq("starve_gnt", 32'(dma_gnt), 32'd0);
      check_eq("starve_stall", 32'(cpu_stall), 32'd0);
      next_cycle();
    end
    sb.push_back(32'h1234_5678);
    @(negedge clk);
    check_eq("force_stall", 32'(cpu_stall), 32'd1);
    check_eq("force_gnt", 32'(dma_gnt), 32'd1);
    check_eq("force_addr", 32'(mem_addr), 32'h0020);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check_eq("after_force_stall", 32'(cpu_stall), 32'd0);
    check_eq("after_force_rvalid", 32'(dma_rvalid), 32'd1);
    next_cycle();

    // Forced DMA write wins over a core store in the same cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0030, 32'h5555_0000);
      next_cycle();
    end
    drive(1'b1, 1'b1, 16'h0030, 32'hAAAA_0000, 1'b1, 1'b1, 16'h0030, 32'h5555_0000);
    @(negedge clk);
    check_eq("fw_stall", 32'(cpu_stall), 32'd1);
    check_eq("fw_mem_d", mem_d, 32'h5555_0000);
    check_eq("fw_mem_we", 32'(mem_we), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check_eq("fw_mem_content", cpu_rdata, 32'h5555_0000);
    next_cycle();

    // Request withdrawn while waiting
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0040, 32'h0);
    @(negedge clk);
    check_eq("wd_gnt", 32'(dma_gnt), 32'd0);
    check_eq("wd_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    check_eq("wd_state", 32'(dut.state), 32'(IDLE));
    check_eq("wd_cnt", 32'(dut.cnt), 32'd0);

    // Reset in FORCE (a read, so nothing may be returned afterwards)
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
      next_cycle();
    end
    @(negedge clk);
    check_eq("rf_stall_pre", 32'(cpu_stall), 32'd1);
    #2 asyn_rst = 1'b1;
    #1;
    check_eq("rf_stall", 32'(cpu_stall), 32'd0);
    check_eq("rf_gnt", 32'(dma_gnt), 32'd0);
    check_eq("rf_rvalid", 32'(dma_rvalid), 32'd0);
    next_cycle();
    asyn_rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check_eq("rf_state", 32'(dut.state), 32'(IDLE));
    check_eq("rf_rvalid_after", 32'(dma_rvalid), 32'd0);
    next_cycle();
    next_cycle();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
